// File: rtl/sum_frame_source_if.sv
// Bundle of the host write channel and the accumulator channel for
// sum_frame_source. The frame source is the slave side; the host/accumulator
// environment is the master side.
interface sum_frame_source_if;
    // host byte loading
    logic [7:0]  wr_data;
    logic        wr_valid;
    logic        wr_ready;
    // frame stream to the accumulator
    logic        data_start;
    logic [7:0]  output_data;
    // accumulator result
    logic [16:0] sum;
    logic        sum_enable;
    // status
    logic        tx_busy;
    logic        done;
    logic        sum_ok;
    logic        timeout;

    modport master (
        output wr_data,
        output wr_valid,
        output sum,
        output sum_enable,
        input  wr_ready,
        input  data_start,
        input  output_data,
        input  tx_busy,
        input  done,
        input  sum_ok,
        input  timeout
    );

    modport slave (
        input  wr_data,
        input  wr_valid,
        input  sum,
        input  sum_enable,
        output wr_ready,
        output data_start,
        output output_data,
        output tx_busy,
        output done,
        output sum_ok,
        output timeout
    );
endinterface

// File: rtl/sum_frame_source.sv
// sum_frame_source: loads a 128-byte frame from the host, streams it to an
// external accumulator (start pulse, 128 bytes, 4 zero flush cycles), then
// waits up to 256 cycles for the accumulator result and reports done with
// sum_ok/timeout.
// Build option: define SUM_FRAME_CHECK_EN to compile in the local 15-bit
// running sum and the 17-bit comparison; without it sum_ok simply reports
// "result arrived" (1 when timeout=0).
module sum_frame_source (
    input logic CLK,
    input logic RST,
    sum_frame_source_if.slave bus
);

    typedef enum logic [2:0] {
        LOAD,
        START,
        SEND,
        FLUSH,
        WAIT,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [7:0] buffer [128];

    logic [6:0] wr_cnt;
    logic [6:0] rd_cnt;
    logic [1:0] flush_cnt;
    logic [7:0] wait_cnt;

    logic       wr_fire;
    logic [7:0] rd_byte;
    logic       sum_match;
    logic       sum_ok_r;
    logic       timeout_r;

    logic       wr_ready_c;
    logic       data_start_c;
    logic [7:0] output_data_c;
    logic       tx_busy_c;
    logic       done_c;

    assign wr_fire = bus.wr_valid && wr_ready_c;
    assign rd_byte = buffer[rd_cnt];

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= LOAD;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and state-based outputs; outputs are forced to their
    // reset values while RST is high so the reset cycle itself is quiet.
    always_comb begin
        state_next    = state;
        wr_ready_c    = 1'b0;
        data_start_c  = 1'b0;
        output_data_c = '0;
        tx_busy_c     = 1'b0;
        done_c        = 1'b0;
        case (state)
            LOAD: begin
                wr_ready_c = !RST;
                if (bus.wr_valid && !RST && wr_cnt == 7'd127) begin
                    state_next = START;
                end
            end
            START: begin
                data_start_c = !RST;
                tx_busy_c    = !RST;
                state_next   = SEND;
            end
            SEND: begin
                output_data_c = RST ? 8'd0 : rd_byte;
                tx_busy_c     = !RST;
                if (rd_cnt == 7'd127) begin
                    state_next = FLUSH;
                end
            end
            FLUSH: begin
                tx_busy_c = !RST;
                if (flush_cnt == 2'd3) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                tx_busy_c = !RST;
                if (bus.sum_enable || wait_cnt == 8'd255) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done_c     = !RST;
                state_next = LOAD;
            end
            default: begin
                state_next = LOAD;
            end
        endcase
    end

    // Frame buffer write port; contents are deliberately not reset
    always_ff @(posedge CLK) begin
        if (wr_fire) begin
            buffer[wr_cnt] <= bus.wr_data;
        end
    end

    // Sequencing counters and the sticky result flags
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_cnt    <= '0;
            rd_cnt    <= '0;
            flush_cnt <= '0;
            wait_cnt  <= '0;
            sum_ok_r  <= 1'b0;
            timeout_r <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    if (wr_fire) begin
                        wr_cnt <= wr_cnt + 7'd1;
                    end
                end
                START: begin
                    rd_cnt    <= '0;
                    flush_cnt <= '0;
                    wait_cnt  <= '0;
                end
                SEND: begin
                    rd_cnt <= rd_cnt + 7'd1;
                end
                FLUSH: begin
                    flush_cnt <= flush_cnt + 2'd1;
                end
                WAIT: begin
                    if (bus.sum_enable) begin
                        sum_ok_r  <= sum_match;
                        timeout_r <= 1'b0;
                        wait_cnt  <= '0;
                    end else if (wait_cnt == 8'd255) begin
                        sum_ok_r  <= 1'b0;
                        timeout_r <= 1'b1;
                        wait_cnt  <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                DONE: begin
                    wr_cnt <= '0;
                end
                default: begin
                    wr_cnt <= '0;
                end
            endcase
        end
    end

`ifdef SUM_FRAME_CHECK_EN
    logic [14:0] local_sum;

    // Running sum of the bytes actually emitted; 128*255 fits in 15 bits
    always_ff @(posedge CLK) begin
        if (RST) begin
            local_sum <= '0;
        end else if (state == START) begin
            local_sum <= '0;
        end else if (state == SEND) begin
            local_sum <= local_sum + {7'd0, rd_byte};
        end
    end

    assign sum_match = (bus.sum == {2'b00, local_sum});
`else
    logic unused_sum;

    assign unused_sum = ^bus.sum;
    assign sum_match  = 1'b1;
`endif

    assign bus.wr_ready    = wr_ready_c;
    assign bus.data_start  = data_start_c;
    assign bus.output_data = output_data_c;
    assign bus.tx_busy     = tx_busy_c;
    assign bus.done        = done_c;
    assign bus.sum_ok      = RST ? 1'b0 : sum_ok_r;
    assign bus.timeout     = RST ? 1'b0 : timeout_r;

endmodule
